// File: rtl/ramb4_s16_burst_reader.sv
// Burst read engine for the 16-bit port B of the dual-port block RAM.
// It issues one read per cycle and hides the registered-read latency behind a 2-entry skid buffer.
module ramb4_s16_burst_reader #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16,
  parameter int LEN_WIDTH  = 9
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  START,
  input  logic [ADDR_WIDTH-1:0] START_ADDR,
  input  logic [LEN_WIDTH-1:0]  LEN,
  output logic                  BUSY,
  output logic                  DONE,
  output logic [ADDR_WIDTH-1:0] ADDRB,
  output logic                  ENB,
  output logic                  WEB,
  output logic                  RSTB,
  input  logic [DATA_WIDTH-1:0] DOB,
  output logic [DATA_WIDTH-1:0] DOUT,
  output logic                  DOUT_VALID,
  input  logic                  DOUT_READY,
  output logic                  DOUT_LAST
);

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  localparam logic [LEN_WIDTH-1:0] MAX_LEN = LEN_WIDTH'(2 ** ADDR_WIDTH);

  state_t                  state_r;
  state_t                  state_s;
  logic [ADDR_WIDTH-1:0]   addr_r;
  logic [LEN_WIDTH-1:0]    issue_cnt_r;
  logic [LEN_WIDTH-1:0]    out_cnt_r;
  logic                    inflight_r;
  logic                    done_r;
  logic [1:0]              occ_r;
  logic [DATA_WIDTH-1:0]   data0_r;
  logic [DATA_WIDTH-1:0]   data1_r;

  logic [LEN_WIDTH-1:0]    len_eff_s;
  logic                    accept_s;
  logic                    pop_s;
  logic                    last_s;
  logic                    finish_s;
  logic [2:0]              level_s;
  logic                    enb_s;

  assign len_eff_s = (LEN > MAX_LEN) ? MAX_LEN : LEN;
  assign accept_s  = (state_r == S_IDLE) && START;
  assign pop_s     = (occ_r != 2'd0) && DOUT_READY;
  assign last_s    = (occ_r != 2'd0) && (out_cnt_r == LEN_WIDTH'(1));
  assign finish_s  = pop_s && last_s;
  // Buffered words plus the read in flight, less the word leaving this cycle.
  assign level_s   = {1'b0, occ_r} + {2'b00, inflight_r} - {2'b00, pop_s};

  // State register
  always_ff @(posedge CLK) begin
    if (RST) state_r <= S_IDLE;
    else     state_r <= state_s;
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE:  if (START && (len_eff_s != '0)) state_s = S_RUN;
               else                            state_s = S_IDLE;
      S_RUN:   if (finish_s) state_s = S_IDLE;
               else          state_s = S_RUN;
      default: state_s = S_IDLE;
    endcase
  end

  // Read-issue decision
  always_comb begin
    enb_s = 1'b0;
    if ((state_r == S_RUN) && (issue_cnt_r != '0) && (level_s < 3'd2)) enb_s = 1'b1;
    else                                                                enb_s = 1'b0;
  end

  // Address, counters, in-flight tracking and done pulse
  always_ff @(posedge CLK) begin
    if (RST) begin
      addr_r      <= '0;
      issue_cnt_r <= '0;
      out_cnt_r   <= '0;
      inflight_r  <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      inflight_r <= enb_s;
      done_r     <= (accept_s && (len_eff_s == '0)) || finish_s;
      if (accept_s) begin
        addr_r      <= START_ADDR;
        issue_cnt_r <= len_eff_s;
        out_cnt_r   <= len_eff_s;
      end else begin
        if (enb_s) begin
          addr_r      <= addr_r + ADDR_WIDTH'(1);
          issue_cnt_r <= issue_cnt_r - LEN_WIDTH'(1);
        end
        if (pop_s) out_cnt_r <= out_cnt_r - LEN_WIDTH'(1);
      end
    end
  end

  // Two-entry skid buffer; entry 0 is the head
  always_ff @(posedge CLK) begin
    if (RST) begin
      occ_r   <= 2'd0;
      data0_r <= '0;
      data1_r <= '0;
    end else begin
      case ({inflight_r, pop_s})
        2'b10: begin
          if (occ_r == 2'd0) data0_r <= DOB;
          else               data1_r <= DOB;
          occ_r <= occ_r + 2'd1;
        end
        2'b01: begin
          data0_r <= data1_r;
          occ_r   <= occ_r - 2'd1;
        end
        2'b11: begin
          if (occ_r == 2'd1) begin
            data0_r <= DOB;
          end else begin
            data0_r <= data1_r;
            data1_r <= DOB;
          end
        end
        default: occ_r <= occ_r;
      endcase
    end
  end

  assign BUSY       = (state_r == S_RUN);
  assign DONE       = done_r;
  assign ADDRB      = addr_r;
  assign ENB        = enb_s;
  assign WEB        = 1'b0;
  assign RSTB       = 1'b0;
  assign DOUT       = data0_r;
  assign DOUT_VALID = (occ_r != 2'd0);
  assign DOUT_LAST  = last_s;

endmodule

// File: tb/tb_ramb4_s16_burst_reader.sv
// Scoreboard bench for ramb4_s16_burst_reader with a behavioural 256x16 registered-read RAM.
module tb_ramb4_s16_burst_reader;

  logic        CLK = 1'b0;
  logic        RST;
  logic        START;
  logic [7:0]  START_ADDR;
  logic [8:0]  LEN;
  logic        BUSY, DONE, ENB, WEB, RSTB;
  logic [7:0]  ADDRB;
  logic [15:0] DOB = 16'h0000;
  logic [15:0] DOUT;
  logic        DOUT_VALID, DOUT_READY, DOUT_LAST;

  logic [15:0] mem [256];
  logic [16:0] exp_q [$];
  logic [7:0]  addr_log [$];
  int          checks = 0;
  int          errors = 0;
  int          issued = 0;
  int          accepted = 0;
  logic        prev_hold = 1'b0;
  logic [16:0] prev_word = 17'h0;

  ramb4_s16_burst_reader #(.ADDR_WIDTH(8), .DATA_WIDTH(16), .LEN_WIDTH(9)) dut (
    .CLK(CLK), .RST(RST), .START(START), .START_ADDR(START_ADDR), .LEN(LEN),
    .BUSY(BUSY), .DONE(DONE), .ADDRB(ADDRB), .ENB(ENB), .WEB(WEB), .RSTB(RSTB),
    .DOB(DOB), .DOUT(DOUT), .DOUT_VALID(DOUT_VALID), .DOUT_READY(DOUT_READY),
    .DOUT_LAST(DOUT_LAST)
  );

  always #5 CLK = ~CLK;

  // Port B RAM model: one-cycle registered read
  always @(posedge CLK) begin
    if (ENB) DOB <= mem[ADDRB];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every handshake and checks hold/outstanding rules
  always @(negedge CLK) begin
    if (RST) begin
      issued    = 0;
      accepted  = 0;
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        check("stall_valid", 32'(DOUT_VALID), 32'd1);
        check("stall_stable", 32'({DOUT_LAST, DOUT}), 32'(prev_word));
      end
      if (ENB) begin
        addr_log.push_back(ADDRB);
        issued++;
      end
      if (DOUT_VALID && DOUT_READY) begin
        accepted++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word: got last=%0d data=%0h expected no word", DOUT_LAST, DOUT);
        end else begin
          check("dout_last_data", 32'({DOUT_LAST, DOUT}), 32'(exp_q.pop_front()));
        end
      end
      if (ENB) check("outstanding_le2", 32'((issued - accepted) <= 2), 32'd1);
      prev_hold = DOUT_VALID && !DOUT_READY;
      prev_word = {DOUT_LAST, DOUT};
    end
  end

  task automatic check_outputs_zero(input string tag);
    check({tag, "_busy"},  32'(BUSY), 32'd0);
    check({tag, "_done"},  32'(DONE), 32'd0);
    check({tag, "_enb"},   32'(ENB), 32'd0);
    check({tag, "_addrb"}, 32'(ADDRB), 32'd0);
    check({tag, "_dout"},  32'(DOUT), 32'd0);
    check({tag, "_valid"}, 32'(DOUT_VALID), 32'd0);
    check({tag, "_last"},  32'(DOUT_LAST), 32'd0);
  endtask

  // exp_done / exp_first: -2 skips the check, -1 for first valid means none expected
  task automatic do_burst(input logic [7:0] a, input logic [8:0] len, input logic [31:0] rpat,
                          input bit chain, input int bogus_at, input int exp_done, input int exp_first);
    int n, base, done_at, first_v, mism;
    bit got;
    logic [7:0]  ea;
    logic [15:0] d;
    n = (len > 9'd256) ? 256 : int'(len);
    for (int i = 0; i < n; i++) begin
      ea = a + 8'(i);
      d  = 16'hA500 + {8'h00, ea};
      exp_q.push_back({(i == n - 1), d});
    end
    base = addr_log.size();
    if (!chain) begin
      @(posedge CLK);
      #1;
    end
    START = 1'b1; START_ADDR = a; LEN = len; DOUT_READY = rpat[0];
    got = 1'b0; done_at = -1; first_v = -1;
    for (int j = 1; j <= 400 && !got; j++) begin
      @(posedge CLK);
      #1;
      START = (j == bogus_at);
      if (j == bogus_at) begin
        START_ADDR = 8'h80;
        LEN        = 9'd5;
      end
      DOUT_READY = (j < 32) ? rpat[j] : 1'b1;
      if (j == 1) check("busy_cycle1", 32'(BUSY), 32'(n > 0));
      if (DOUT_VALID && first_v < 0) first_v = j;
      if (DONE) begin
        got     = 1'b1;
        done_at = j;
      end
    end
    check("done_seen", 32'(got), 32'd1);
    if (exp_done != -2)  check("done_cycle", 32'(done_at), 32'(exp_done));
    if (exp_first != -2) check("first_valid_cycle", 32'(first_v), 32'(exp_first));
    check("enb_count", 32'(addr_log.size() - base), 32'(n));
    mism = 0;
    for (int i = 0; i < n; i++) begin
      ea = a + 8'(i);
      if (base + i >= addr_log.size()) mism++;
      else if (addr_log[base + i] != ea) mism++;
    end
    check("addrb_sequence", 32'(mism), 32'd0);
    check("words_outstanding", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'hA500 + 16'(i);
    RST = 1'b1; START = 1'b0; START_ADDR = 8'h00; LEN = 9'd0; DOUT_READY = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    check_outputs_zero("reset");
    check("web_const", 32'(WEB), 32'd0);
    check("rstb_const", 32'(RSTB), 32'd0);
    RST = 1'b0;

    do_burst(8'h10, 9'd4,   32'hFFFF_FFFF, 1'b0, -1, 7, 3);
    do_burst(8'h20, 9'd3,   32'hFFFF_FFFF, 1'b1, -1, 6, 3);
    do_burst(8'hFE, 9'd4,   32'hFFFF_FFFF, 1'b0, -1, 7, 3);
    do_burst(8'h00, 9'd8,   32'hFFFF_FFE9, 1'b0, -1, -2, 3);
    do_burst(8'h30, 9'd0,   32'hFFFF_FFFF, 1'b0, -1, 1, -1);
    do_burst(8'h55, 9'd300, 32'hFFFF_FFFF, 1'b0, -1, 259, 3);
    check("wrap_back_addr", 32'(ADDRB), 32'h55);
    do_burst(8'h60, 9'd2,   32'hFFFF_FFFF, 1'b0, 2, 5, 3);
    repeat (3) @(posedge CLK);
    #1;
    check("busy_after_ignored_start", 32'(BUSY), 32'd0);

    // Reset mid-burst with a word buffered and a read in flight
    for (int i = 0; i < 8; i++) exp_q.push_back({(i == 7), 16'hA540 + 16'(i)});
    @(posedge CLK);
    #1;
    START = 1'b1; START_ADDR = 8'h40; LEN = 9'd8; DOUT_READY = 1'b0;
    repeat (3) begin
      @(posedge CLK);
      #1;
      START = 1'b0;
    end
    check("pre_reset_valid", 32'(DOUT_VALID), 32'd1);
    RST = 1'b1;
    @(posedge CLK);
    #1;
    check_outputs_zero("midreset");
    exp_q.delete();
    RST = 1'b0;
    DOUT_READY = 1'b1;
    do_burst(8'h20, 9'd3, 32'hFFFF_FFFF, 1'b0, -1, 6, 3);

    repeat (2) @(posedge CLK);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ramb4_s16_burst_reader.md
Name: ramb4_s16_burst_reader

Overview:
Burst read engine on the 16-bit port B of the 512x8 / 256x16 dual-port block RAM. It takes a start word address and a word count, and issues one read per cycle to port B. It absorbs the RAM's 1-cycle registered-read latency in a 2-entry skid buffer and presents the words on a valid/ready stream toward the downstream consumer. Port A remains owned by the byte-wide producer; this block never writes.

Parameters:
ADDR_WIDTH, 8, port B word address width (256 words)
DATA_WIDTH, 16, port B data width
LEN_WIDTH, 9, burst length field width (max legal length 2**ADDR_WIDTH = 256)

Ports:
CLK  in  1  single clock; also drives RAM CLKB
RST  in  1  synchronous, active-high reset
START  in  1  burst request, sampled when BUSY=0
START_ADDR  in  ADDR_WIDTH  first word address of burst
LEN  in  LEN_WIDTH  words to read; 0 = empty burst; >256 clamped to 256
BUSY  out  1  burst in progress
DONE  out  1  one-cycle pulse at burst end
ADDRB  out  ADDR_WIDTH  RAM port B address
ENB  out  1  RAM port B enable; high only on cycles that issue a read
WEB  out  1  constant 0
RSTB  out  1  constant 0
DOB  in  DATA_WIDTH  RAM port B read data; valid the cycle after ENB=1
DOUT  out  DATA_WIDTH  stream data
DOUT_VALID  out  1  stream valid
DOUT_READY  in  1  stream ready
DOUT_LAST  out  1  high with the final word of a burst

Behaviour:
- Reset values (next cycle after RST=1): BUSY=0, DONE=0, ENB=0, ADDRB=0, DOUT=0, DOUT_VALID=0, DOUT_LAST=0.
- Reset clears all state, including buffer contents and in-flight reads. RST has priority over START and every other input.
- FSM states:
  - IDLE: START=1 loads addr=START_ADDR, issue_cnt=out_cnt=min(LEN,256) and goes to RUN. If LEN=0, it stays in IDLE and pulses DONE the next cycle with no ENB and no data.
  - RUN: issues reads and drains the buffer. When the final word is accepted (DOUT_VALID & DOUT_READY & DOUT_LAST), it goes to IDLE and pulses DONE in the following cycle.
- BUSY=1 exactly while in RUN. START is ignored while BUSY=1. START in the same cycle that DONE is pulsed is accepted, because the FSM is already in IDLE.
- Issue rule: ENB=1 in a cycle iff issue_cnt>0 and (buffer occupancy + in-flight read − pop this cycle) < 2. On each issue, addr increments and issue_cnt decrements.
- Address wraps 255→0 modulo 2**ADDR_WIDTH, with no error flag.
- Pipeline: a read issued in cycle n returns on DOB in cycle n+1 and is written into the buffer at the end of cycle n+1.
- Latency: START accepted in cycle 0 → ENB=1 with ADDRB=START_ADDR in cycle 1 → DOUT_VALID=1 in cycle 3.
- Throughput: with DOUT_READY held high, one word per cycle. An N-word burst ends with the last handshake in cycle N+2, and DONE=1 in cycle N+3.
- Buffer: 2-entry FIFO, head drives DOUT. While DOUT_VALID=1 and DOUT_READY=0, DOUT and DOUT_LAST hold stable. A buffered word is never dropped or duplicated.
- Stall: DOUT_READY=0 stops issuing once the buffer plus in-flight count reaches 2. Resuming restores 1 word/cycle with no bubble beyond the RAM latency.
- DOUT_LAST is asserted on the word whose out_cnt equals 1; out_cnt decrements on each handshake.
- Simultaneous push and pop on a full buffer is legal and keeps occupancy at 2.

Test Plan:
- Preload words 0x00..0xFF with value = 0xA500 + addr. START_ADDR=0x10, LEN=4, READY=1 → DOUT sequence 0xA510, 0xA511, 0xA512, 0xA513. First DOUT_VALID in cycle 3, LAST on 0xA513, DONE one cycle later, exactly 4 ENB cycles.
- Wrap case: START_ADDR=0xFE, LEN=4 → ADDRB sequence FE, FF, 00, 01; data 0xA5FE, 0xA5FF, 0xA500, 0xA501.
- Backpressure: LEN=8 with READY toggling 1,0,0,1,0,1,1,1,… → all 8 words delivered in order, DOUT stable while stalled, never more than 2 reads outstanding+buffered, ENB low during stalls.
- Edge lengths:
  - LEN=0 → DONE pulse, no ENB, no VALID.
  - LEN=300 → exactly 256 words, address wraps fully back to START_ADDR.
- START while BUSY (LEN=2 burst, second START at cycle 2 with a different address) is ignored. A START in the DONE cycle launches a new burst.
- RST asserted mid-burst with VALID=1 and a read in flight → next cycle all outputs 0, FSM in IDLE, no stale word emitted after the subsequent START.
